// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding, frame width and line idle level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver status and buffer read port bundle.
// master = receiver side, slave = consumer side.
interface uart_receiver_if #(
  parameter int AW = 6
);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [AW:0]   byte_count;
  logic          frame_error;
  logic          overflow;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (
    output byte_valid, byte_data, byte_count,
    output frame_error, overflow, done, rd_data,
    input  rd_addr
  );

  modport slave (
    input  byte_valid, byte_data, byte_count,
    input  frame_error, overflow, done, rd_data,
    output rd_addr
  );

endinterface

// File: rtl/uart_rx_buffer.sv
// Byte store for received frames: one write port,
// one registered read port (read-before-write).
module uart_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock_10KHz,
  input  logic          Reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // storage array; contents are not cleared by reset
  always_ff @(posedge clock_10KHz) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read, sees old data on same-address write
  always_ff @(posedge clock_10KHz or negedge Reset_n) begin
    if (!Reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with byte buffer and status flags.
// Optional 2-flop input synchronizer: UART_RX_SYNC_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int AW             = 6,
  parameter int EXPECTED_BYTES = 38
) (
  input  logic clock_10KHz,
  input  logic Reset_n,
  input  logic RXD,
  uart_receiver_if.master rx_if
);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // bring RXD into the clock domain
  always_ff @(posedge clock_10KHz or negedge Reset_n) begin
    if (!Reset_n) sync_q <= {2{IDLE_LEVEL}};
    else          sync_q <= {sync_q[0], RXD};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RXD;
`endif

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        accept, stop_bad;
  logic        full, wr_en;
  logic        valid_q, ferr_q, ovf_q;
  logic [7:0]  data_q;
  logic [AW:0] count_q;

  // next-state, shift and event decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    accept    = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_s != IDLE_LEVEL) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        sh_d = {rx_s, sh_q[7:1]};
        if (bit_cnt_q == 3'(DATA_BITS - 1))
          state_d = STOP;
        else
          bit_cnt_d = bit_cnt_q + 3'd1;
      end
      STOP: begin
        if (rx_s == IDLE_LEVEL) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else begin
          stop_bad = 1'b1;
          state_d  = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s == IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and shift register state
  always_ff @(posedge clock_10KHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
    end
  end

  assign full  = int'(count_q) >= DEPTH;
  assign wr_en = accept && !full;

  // strobe, last byte, count and sticky flags
  always_ff @(posedge clock_10KHz or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept)         data_q  <= sh_q;
      if (wr_en)          count_q <= count_q + {{AW{1'b0}}, 1'b1};
      if (accept && full) ovf_q   <= 1'b1;
      if (stop_bad)       ferr_q  <= 1'b1;
    end
  end

  assign rx_if.byte_valid  = valid_q;
  assign rx_if.byte_data   = data_q;
  assign rx_if.byte_count  = count_q;
  assign rx_if.frame_error = ferr_q;
  assign rx_if.overflow    = ovf_q;
  assign rx_if.done        = int'(count_q) >= EXPECTED_BYTES;

  uart_rx_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock_10KHz (clock_10KHz),
    .Reset_n     (Reset_n),
    .wr_en       (wr_en),
    .wr_addr     (count_q[AW-1:0]),
    .wr_data     (sh_q),
    .rd_addr     (rx_if.rd_addr),
    .rd_data     (rx_if.rd_data)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver.
// Scoreboard of expected bytes plus table-driven frames.
module tb_uart_receiver;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int EXP_B = 38;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clock_10KHz = 1'b0;
  logic Reset_n     = 1'b0;
  logic RXD         = 1'b1;

  uart_receiver_if #(.AW(AW)) rx_if ();

  uart_receiver #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .EXPECTED_BYTES (EXP_B)
  ) dut (
    .clock_10KHz (clock_10KHz),
    .Reset_n     (Reset_n),
    .RXD         (RXD),
    .rx_if       (rx_if)
  );

  always #50 clock_10KHz = ~clock_10KHz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int strobes = 0;
  int done_at = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sent [$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    int         exp_ferr;
  } vec_t;

  vec_t vt [6];

  always @(posedge clock_10KHz) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // strobe monitor: pop and compare the scoreboard
  always @(negedge clock_10KHz) begin
    if (Reset_n && rx_if.byte_valid === 1'b1) begin
      strobes++;
      if (rx_if.done && done_at == 0) done_at = strobes;
      check("latency", 32'(cyc - stop_cyc), 32'(LAT));
      if (exp_q.size() == 0)
        check("strobe_expected", 32'(exp_q.size()), 32'd1);
      else
        check("byte_data", 32'(rx_if.byte_data),
              32'(exp_q.pop_front()));
    end
  end

  task automatic line(input logic v, input int n);
    repeat (n) begin
      @(negedge clock_10KHz);
      RXD = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sb);
    @(negedge clock_10KHz);
    RXD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock_10KHz);
      RXD = d[i];
    end
    @(negedge clock_10KHz);
    RXD = sb;
    stop_cyc = cyc;
    if (sb) exp_q.push_back(d);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      @(negedge clock_10KHz);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rd_chk(input string nm, input int a,
                        input logic [7:0] e);
    @(negedge clock_10KHz);
    rx_if.rd_addr = AW'(a);
    @(negedge clock_10KHz);
    check(nm, 32'(rx_if.rd_data), 32'(e));
  endtask

  task automatic zero_chk();
    check("rst_valid", 32'(rx_if.byte_valid), 32'd0);
    check("rst_data", 32'(rx_if.byte_data), 32'd0);
    check("rst_count", 32'(rx_if.byte_count), 32'd0);
    check("rst_ferr", 32'(rx_if.frame_error), 32'd0);
    check("rst_ovf", 32'(rx_if.overflow), 32'd0);
    check("rst_done", 32'(rx_if.done), 32'd0);
    check("rst_rdata", 32'(rx_if.rd_data), 32'd0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    RXD = 1'b1;
    rx_if.rd_addr = '0;
    exp_q.delete();
    sent.delete();
    repeat (2) @(negedge clock_10KHz);
    Reset_n = 1'b1;
    strobes = 0;
    done_at = 0;
    line(1'b1, 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    rx_if.rd_addr = '0;
    #20;
    zero_chk();

    // table: good frames mixed with one bad stop bit
    vt[0] = '{8'h41, 1'b1, 1, 0};
    vt[1] = '{8'hA5, 1'b1, 2, 0};
    vt[2] = '{8'h00, 1'b1, 3, 0};
    vt[3] = '{8'h3C, 1'b0, 3, 1};
    vt[4] = '{8'hFF, 1'b1, 4, 1};
    vt[5] = '{8'h80, 1'b1, 5, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].data, vt[i].stop);
      if (!vt[i].stop) begin
        line(1'b0, 3);
        line(1'b1, 1);
      end else begin
        sent.push_back(vt[i].data);
      end
      drain();
      line(1'b1, 3);
      check("tbl_count", 32'(rx_if.byte_count), 32'(vt[i].exp_cnt));
      check("tbl_ferr", 32'(rx_if.frame_error), 32'(vt[i].exp_ferr));
    end
    check("tbl_strobes", 32'(strobes), 32'd5);
    for (int i = 0; i < sent.size(); i++)
      rd_chk("tbl_mem", i, sent[i]);

    // 38 back-to-back frames, done on the last
    do_reset();
    for (int i = 0; i < EXP_B; i++) begin
      d = 8'($urandom_range(0, 255));
      sent.push_back(d);
      send_frame(d, 1'b1);
    end
    drain();
    line(1'b1, 3);
    check("b2b_strobes", 32'(strobes), 32'(EXP_B));
    check("b2b_done_at", 32'(done_at), 32'(EXP_B));
    check("b2b_done", 32'(rx_if.done), 32'd1);
    check("b2b_count", 32'(rx_if.byte_count), 32'(EXP_B));
    for (int i = 0; i < EXP_B; i++)
      rd_chk("b2b_mem", i, sent[i]);

    // bad stop held low, then a good frame
    do_reset();
    send_frame(8'h55, 1'b0);
    line(1'b0, 3);
    line(1'b1, 1);
    send_frame(8'h2A, 1'b1);
    drain();
    line(1'b1, 4);
    check("ferr_sticky", 32'(rx_if.frame_error), 32'd1);
    check("ferr_count", 32'(rx_if.byte_count), 32'd1);
    check("ferr_strobes", 32'(strobes), 32'd1);
    rd_chk("ferr_mem0", 0, 8'h2A);

    // overflow: one frame past capacity
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      sent.push_back(d);
      send_frame(d, 1'b1);
    end
    drain();
    line(1'b1, 3);
    check("ovf_count", 32'(rx_if.byte_count), 32'(DEPTH));
    check("ovf_flag", 32'(rx_if.overflow), 32'd1);
    check("ovf_strobes", 32'(strobes), 32'(DEPTH + 1));
    check("ovf_lastdata", 32'(rx_if.byte_data), 32'(sent[DEPTH]));
    rd_chk("ovf_mem63", DEPTH - 1, sent[DEPTH-1]);
    rd_chk("ovf_mem0", 0, sent[0]);

    // reset pulse in the 4th data bit
    do_reset();
    send_frame(8'hC3, 1'b1);
    drain();
    rd_chk("pre_rst_mem0", 0, 8'hC3);
    d = 8'h5A;
    @(negedge clock_10KHz);
    RXD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_10KHz);
      RXD = d[i];
    end
    #20;
    Reset_n = 1'b0;
    #5;
    zero_chk();
    exp_q.delete();
    RXD = 1'b1;
    @(negedge clock_10KHz);
    Reset_n = 1'b1;
    strobes = 0;
    line(1'b1, 2);
    send_frame(8'h96, 1'b1);
    drain();
    line(1'b1, 2);
    check("post_rst_count", 32'(rx_if.byte_count), 32'd1);
    check("post_rst_data", 32'(rx_if.byte_data), 32'h96);
    check("post_rst_strobes", 32'(strobes), 32'd1);
    rd_chk("post_rst_mem0", 0, 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
